// File: rtl/bqu_pkg.sv
// Shared types and constants for the batch queue unit: FSM states, default
// framing symbols and pop-order encoding.
package bqu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    FINISH,
    DONE
  } state_t;

  localparam logic [7:0] EOB_DEF  = 8'h3B;
  localparam logic [7:0] EOS_DEF  = 8'h24;
  localparam logic [7:0] NULL_DEF = 8'h30;

  localparam logic MODE_FIFO = 1'b0;
  localparam logic MODE_LIFO = 1'b1;

endpackage

// File: rtl/bqu_ring_buf.sv
// Circular item buffer with head (oldest) and tail (next free) pointers;
// pops may come from either end so the same contents serve FIFO or LIFO use.
module bqu_ring_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_head,
  input  logic              pop_tail,
  output logic [DATA_W-1:0] head_data,
  output logic [DATA_W-1:0] tail_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  tail_prev;
  logic              push_ok;
  logic              pop_h_ok;
  logic              pop_t_ok;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign tail_prev = tail - PTR_W'(1);
  assign head_data = mem[head];
  assign tail_data = mem[tail_prev];

  // Head pop has priority; a tail pop never coincides with a push.
  assign push_ok  = push && !full;
  assign pop_h_ok = pop_head && !empty;
  assign pop_t_ok = pop_tail && !empty && !pop_head && !push;

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop_h_ok) head <= head + PTR_W'(1);
      if (push_ok) tail <= tail + PTR_W'(1);
      else if (pop_t_ok) tail <= tail_prev;
      if (push_ok && !(pop_h_ok || pop_t_ok)) count <= count + CNT_W'(1);
      else if (!push_ok && (pop_h_ok || pop_t_ok)) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/batch_queue_unit.sv
// Batch queue unit: loads a byte stream into a ring buffer and drains a
// per-batch pop count in FIFO or LIFO order. Optional RESIDUE_DRAIN_EN drains leftovers at end of stream.
module batch_queue_unit
  import bqu_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 16,
  parameter int                CNT_W    = $clog2(DEPTH + 1),
  parameter logic [DATA_W-1:0] EOB_SYM  = DATA_W'(EOB_DEF),
  parameter logic [DATA_W-1:0] EOS_SYM  = DATA_W'(EOS_DEF),
  parameter logic [DATA_W-1:0] NULL_SYM = DATA_W'(NULL_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mode,
  input  logic [CNT_W-1:0]  pop_num,
  output logic              busy,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              done_batch,
  output logic              done_all,
  output logic              overflow,
  output logic              valid_res
);

  state_t            state;
  logic              batch_mode;
  logic [CNT_W-1:0]  remaining;
  logic              null_pending;
  logic              accepting;
  logic              is_eob;
  logic              is_eos;
  logic              push;
  logic              pop_head;
  logic              pop_tail;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] tail_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  assign accepting = ready_in && (state == IDLE || state == LOAD);
  assign is_eob    = (data_in == EOB_SYM);
  assign is_eos    = (data_in == EOS_SYM);
  assign push      = accepting && !is_eob && !is_eos;

  always_comb begin
    pop_head = 1'b0;
    pop_tail = 1'b0;
    if (state == DRAIN && !null_pending && remaining != '0) begin
      if (batch_mode == MODE_FIFO) pop_head = 1'b1;
      else pop_tail = 1'b1;
    end
`ifdef RESIDUE_DRAIN_EN
    if (state == FINISH && !empty) pop_head = 1'b1;
`endif
  end

  bqu_ring_buf #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(data_in),
    .pop_head (pop_head),
    .pop_tail (pop_tail),
    .head_data(head_data),
    .tail_data(tail_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

`ifdef RESIDUE_DRAIN_EN
  logic res_strobe;
  assign valid_res = res_strobe;
`else
  assign valid_res = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      batch_mode   <= MODE_FIFO;
      remaining    <= '0;
      null_pending <= 1'b0;
      busy         <= 1'b0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      done_batch   <= 1'b0;
      done_all     <= 1'b0;
      overflow     <= 1'b0;
`ifdef RESIDUE_DRAIN_EN
      res_strobe   <= 1'b0;
`endif
    end else begin
      valid_out  <= 1'b0;
      done_batch <= 1'b0;
`ifdef RESIDUE_DRAIN_EN
      res_strobe <= 1'b0;
`endif
      unique case (state)
        IDLE, LOAD: begin
          if (ready_in) begin
            if (is_eob) begin
              // The batch pops min(n, count); zero means a single NULL output.
              batch_mode   <= mode;
              remaining    <= (pop_num < count) ? pop_num : count;
              null_pending <= (pop_num == '0) || empty;
              state        <= DRAIN;
            end else if (is_eos) begin
              state <= FINISH;
            end else begin
              state <= LOAD;
              if (full) overflow <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (null_pending) begin
            valid_out    <= 1'b1;
            busy         <= 1'b1;
            data_out     <= NULL_SYM;
            null_pending <= 1'b0;
          end else if (remaining != '0) begin
            valid_out <= 1'b1;
            busy      <= 1'b1;
            data_out  <= (batch_mode == MODE_FIFO) ? head_data : tail_data;
            remaining <= remaining - CNT_W'(1);
          end else begin
            busy       <= 1'b0;
            done_batch <= 1'b1;
            state      <= LOAD;
          end
        end
        FINISH: begin
`ifdef RESIDUE_DRAIN_EN
          if (!empty) begin
            res_strobe <= 1'b1;
            data_out   <= head_data;
          end else begin
            done_all <= 1'b1;
            state    <= DONE;
          end
`else
          done_all <= 1'b1;
          state    <= DONE;
`endif
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/batch_queue_unit.md
Name: batch_queue_unit

Overview:
- Parametrised successor to the team's fixed 8-bit people/thing queue units.
- One circular buffer serves either FIFO or LIFO pops, selected per batch by `mode`.
- Fed by a byte stream with end-of-batch and end-of-stream symbols, and drains a per-batch pop count.
- Sits beside the existing queue units at CIPU top level.

Parameters:
- DATA_W, 8, item/symbol width in bits.
- DEPTH, 16, buffer capacity in items; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter and of `pop_num`.
- EOB_SYM, 8'h3B, end-of-batch symbol (';').
- EOS_SYM, 8'h24, end-of-stream symbol ('$').
- NULL_SYM, 8'h30, emitted when a batch pops nothing ('0').

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ready_in  in  1  `data_in` holds a valid item or symbol this cycle.
- data_in  in  DATA_W  item or symbol.
- mode  in  1  0 = FIFO pop (oldest first), 1 = LIFO pop (newest first); sampled with EOB.
- pop_num  in  CNT_W  items to pop for this batch; sampled with EOB.
- busy  out  1  high while draining; the source must hold `ready_in` low.
- valid_out  out  1  `data_out` holds a popped item or NULL_SYM.
- data_out  out  DATA_W  popped data.
- done_batch  out  1  one-cycle pulse after a batch drain completes.
- done_all  out  1  stays high after the EOS sequence completes, until reset.
- overflow  out  1  sticky; set when a push is dropped because the buffer is full.
- valid_res  out  1  residue drain strobe (feature only; otherwise tied 0).

Behaviour:
- Reset (asynchronous, active-high): every output is 0.
  - head, tail and count are 0; state is IDLE.
  - Reset asserted mid-drain aborts the drain immediately; no `done_batch`.
- Registered outputs: EOB accepted at cycle t gives the first `valid_out` at t+1.
- States:
  - IDLE: first `ready_in` goes to LOAD with the same handling as LOAD.
  - LOAD: on `ready_in`:
    - Non-symbol byte is pushed at tail. If count==DEPTH it is dropped and `overflow` is set.
    - EOB_SYM latches `mode` and `pop_num` (n) and goes to DRAIN; `busy` rises at t+1.
    - EOS_SYM goes to FINISH.
  - DRAIN: one pop per cycle, `valid_out`=1.
    - FIFO pops at head with head++; LIFO pops at tail-1 with tail--. count-- either way.
    - Pops min(n, count) items.
    - n==0 or count==0: exactly one cycle of `data_out`=NULL_SYM, buffer unchanged.
    - Cycle after the last output: `done_batch`=1 and `busy`=0, then back to LOAD.
    - `ready_in` during DRAIN is ignored; the byte is not stored.
  - FINISH: without the feature, `done_all`=1 on the next cycle, then hold DONE.
  - DONE: all input ignored until reset.
- Pointers: log2(DEPTH) bits and wrap modulo DEPTH. count ranges 0..DEPTH.
  - FIFO and LIFO pops can interleave across batches on the same buffer contents.
- `data_out` holds its last value when `valid_out`=0.

Optional Feature:
- Macro RESIDUE_DRAIN_EN.
- Defined: FINISH drains every remaining item in FIFO order, one per cycle, with `valid_res`=1 and `valid_out`=0. `done_all` rises the cycle after the last item, or the cycle after EOS if the buffer is empty.
- Not defined: residue is discarded, `valid_res` is tied 0, and `done_all` follows EOS by one cycle.

Decomposition:
- Package `bqu_pkg`:
  - state enum: IDLE, LOAD, DRAIN, FINISH, DONE.
  - default symbol constants EOB/EOS/NULL.
  - mode encoding constants MODE_FIFO / MODE_LIFO.
- One natural sub-module, `bqu_ring_buf`:
  - DEPTH×DATA_W register array with head/tail/count.
  - push, pop_head and pop_tail ports; full/empty flags.
- The FSM and output registers stay in the top module.

Test Plan:
- FIFO batch: push 'A','B','C', EOB with mode=0, n=2 → `data_out` 'A','B' on t+1 and t+2; `done_batch` at t+3; count=1.
- LIFO batch: push 'A','B','C', EOB with mode=1, n=2 → 'C','B'; then EOB with mode=0, n=5 → 'A' only, then `done_batch`.
- Null pop: EOB with n=0, or with an empty buffer → one cycle of 8'h30; state and count unchanged.
- Overflow and wrap: push DEPTH+1 items → `overflow`=1 and count=DEPTH. Pop 4 FIFO, push 4 more, pop all FIFO → 5..DEPTH then the 4 new items in order across the wrap.
- Residue with RESIDUE_DRAIN_EN: remaining 'X','Y' then EOS → `valid_res` with 'X','Y', then `done_all`=1. Without the macro, `done_all` one cycle after EOS and `valid_res` stays 0.
- Reset mid-drain: assert `rst` during the second pop of a 3-pop batch → all outputs 0 asynchronously. After release, an EOB pops NULL_SYM because the buffer is empty.
